id_stage: RTL and testbench

// - Decode stage feeding the EX ALU: accepts 32-bit instruction words from fetch via valid/ready,

---
 rtl/id_stage.sv | 87 ++++++++
 tb/tb_id_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: decode stage with 8x16 register file, flags and one output register; ID_HAZARD_STALL_EN adds a RAW scoreboard stall
module id_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [1:0]        First_LD,
    output logic              Special_encoding,
    output logic [3:0]        Second_LD,
    output logic [3:0]        B_cond,
    output logic [2:0]        ALU_OC,
    output logic [2:0]        dest_reg,
    output logic [2:0]        pointer_reg,
    output logic [DATA_W-1:0] op_1_reg_value,
    output logic [DATA_W-1:0] op_2_reg_value,
    output logic [DATA_W-1:0] immediate,
    output logic [DATA_W-1:0] offset,
    output logic [3:0]        flags,
    input  logic              wb_en,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_flags_en,
    input  logic [3:0]        wb_flags
);
    logic [DATA_W-1:0] rf [NREGS];
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [2:0]        src1, src2;
    logic              stall, accept;
    assign src1 = if_instr[18:16];
    assign src2 = if_instr[15:13];
    assign if_ready = !rst && !flush && !stall && (!id_valid || ex_ready);
    assign accept = if_valid && if_ready;
`ifdef ID_HAZARD_STALL_EN
    logic [NREGS-1:0] pending;
    logic             writer;
    assign writer = if_instr[29] || (if_instr[31:30] == 2'b00);
    // a writeback landing this cycle is bypassed, so it does not stall
    assign stall = (pending[src1] && !(wb_en && wb_reg == src1)) ||
                   (if_instr[30] && pending[src2] && !(wb_en && wb_reg == src2));
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else for (int i = 0; i < NREGS; i++)
            pending[i] <= (pending[i] && !(wb_en && wb_reg == i[2:0])) ||
                          (accept && writer && if_instr[21:19] == i[2:0]);
    end
`else
    assign stall = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            instr_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            flags    <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (wb_en) rf[wb_reg] <= wb_data;
            if (wb_flags_en) flags <= wb_flags;
            if (accept) begin
                instr_q <= if_instr;
                op1_q   <= (wb_en && wb_reg == src1) ? wb_data : rf[src1];
                op2_q   <= (wb_en && wb_reg == src2) ? wb_data : rf[src2];
            end
            id_valid <= accept || (id_valid && !ex_ready && !flush);
        end
    end
    assign First_LD         = instr_q[31:30];
    assign Special_encoding = instr_q[29];
    assign Second_LD        = instr_q[28:25];
    assign B_cond           = instr_q[28:25];
    assign ALU_OC           = instr_q[24:22];
    assign dest_reg         = instr_q[21:19];
    assign pointer_reg      = instr_q[18:16];
    assign immediate        = instr_q[15:0];
    assign offset           = instr_q[15:0];
    assign op_1_reg_value   = op1_q;
    assign op_2_reg_value   = op2_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
    logic        clk = 0, rst = 1, if_valid = 0, flush = 0, ex_ready = 0;
    logic        wb_en = 0, wb_flags_en = 0;
    logic [31:0] if_instr = 0;
    logic [2:0]  wb_reg = 0;
    logic [15:0] wb_data = 0;
    logic [3:0]  wb_flags = 0;
    logic        if_ready, id_valid, Special_encoding;
    logic [1:0]  First_LD;
    logic [3:0]  Second_LD, B_cond, flags;
    logic [2:0]  ALU_OC, dest_reg, pointer_reg;
    logic [15:0] op_1_reg_value, op_2_reg_value, immediate, offset;
    int checks = 0, failures = 0;
    localparam logic [31:0] I1 = 32'h204B_6000;
    localparam logic [31:0] I2 = 32'h5A00_0055;
    localparam logic [31:0] I3 = 32'h0005_A000;
    localparam logic [31:0] I4 = 32'h0006_0000;
    localparam logic [31:0] I5 = 32'h2010_0000;
    localparam logic [31:0] I6 = 32'h0002_0000;
    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid), .First_LD(First_LD),
        .Special_encoding(Special_encoding), .Second_LD(Second_LD), .B_cond(B_cond),
        .ALU_OC(ALU_OC), .dest_reg(dest_reg), .pointer_reg(pointer_reg),
        .op_1_reg_value(op_1_reg_value), .op_2_reg_value(op_2_reg_value),
        .immediate(immediate), .offset(offset), .flags(flags), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .wb_flags_en(wb_flags_en), .wb_flags(wb_flags)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        if_valid = 1;
        if_instr = I1;
        tick;
        tick;
        chk("rst_if_ready", 32'(if_ready), 0);
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_dest", 32'(dest_reg), 0);
        rst = 0;
        ex_ready = 1;
        #1;
        chk("first_ready", 32'(if_ready), 1);
        tick;
        chk("first_valid", 32'(id_valid), 1);
        chk("first_op1", 32'(op_1_reg_value), 0);
        chk("first_op2", 32'(op_2_reg_value), 0);
        if_valid = 0;
        wb_en = 1;
        wb_reg = 3;
        wb_data = 16'h1234;
        tick;
        chk("consume_valid", 32'(id_valid), 0);
        wb_en = 0;
        if_valid = 1;
        if_instr = I1;
        tick;
        chk("alu_valid", 32'(id_valid), 1);
        chk("alu_op1", 32'(op_1_reg_value), 32'h1234);
        chk("alu_op2", 32'(op_2_reg_value), 32'h1234);
        chk("alu_imm", 32'(immediate), 32'h6000);
        chk("alu_off", 32'(offset), 32'h6000);
        chk("alu_dest", 32'(dest_reg), 1);
        chk("alu_ptr", 32'(pointer_reg), 3);
        chk("alu_spec", 32'(Special_encoding), 1);
        chk("alu_oc", 32'(ALU_OC), 1);
        chk("alu_ld", 32'(First_LD), 0);
        ex_ready = 0;
        if_instr = I2;
        #1;
        chk("hold_ready", 32'(if_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_valid", 32'(id_valid), 1);
            chk("hold_op1", 32'(op_1_reg_value), 32'h1234);
            chk("hold_imm", 32'(immediate), 32'h6000);
        end
        ex_ready = 1;
        #1;
        chk("release_ready", 32'(if_ready), 1);
        tick;
        chk("b2b_valid", 32'(id_valid), 1);
        chk("b2b_imm", 32'(immediate), 32'h0055);
        chk("b2b_ld", 32'(First_LD), 1);
        chk("b2b_bcond", 32'(B_cond), 32'hD);
        chk("b2b_sld", 32'(Second_LD), 32'hD);
        chk("b2b_spec", 32'(Special_encoding), 0);
        if_instr = I3;
        wb_en = 1;
        wb_reg = 5;
        wb_data = 16'hBEEF;
        wb_flags_en = 1;
        wb_flags = 4'hA;
        tick;
        wb_flags_en = 0;
        chk("byp_op1", 32'(op_1_reg_value), 32'hBEEF);
        chk("byp_op2", 32'(op_2_reg_value), 32'hBEEF);
        chk("byp_flags", 32'(flags), 32'hA);
        ex_ready = 0;
        if_valid = 0;
        wb_data = 16'h1111;
        tick;
        chk("held_op1", 32'(op_1_reg_value), 32'hBEEF);
        chk("held_valid", 32'(id_valid), 1);
        flush = 1;
        if_valid = 1;
        if_instr = I2;
        wb_reg = 6;
        wb_data = 16'h0606;
        #1;
        chk("flush_ready", 32'(if_ready), 0);
        tick;
        flush = 0;
        wb_en = 0;
        if_valid = 0;
        chk("flush_valid", 32'(id_valid), 0);
        if_valid = 1;
        if_instr = I4;
        ex_ready = 1;
        tick;
        chk("flushwb_op1", 32'(op_1_reg_value), 32'h0606);
        chk("flushwb_valid", 32'(id_valid), 1);
        if_valid = 0;
        ex_ready = 0;
        rst = 1;
        wb_en = 1;
        wb_data = 16'h7777;
        tick;
        rst = 0;
        wb_en = 0;
        chk("midrst_valid", 32'(id_valid), 0);
        chk("midrst_flags", 32'(flags), 0);
        chk("midrst_ptr", 32'(pointer_reg), 0);
        if_valid = 1;
        ex_ready = 1;
        tick;
        chk("rstwins_op1", 32'(op_1_reg_value), 0);
        if_valid = 0;
        rst = 1;
        tick;
        rst = 0;
        if_valid = 1;
        if_instr = I5;
        tick;
        chk("wr_valid", 32'(id_valid), 1);
        chk("wr_dest", 32'(dest_reg), 2);
        if_instr = I6;
`ifdef ID_HAZARD_STALL_EN
        #1;
        chk("raw_stall0", 32'(if_ready), 0);
        tick;
        tick;
        chk("raw_stall2", 32'(if_ready), 0);
        chk("raw_drain", 32'(id_valid), 0);
        wb_en = 1;
        wb_reg = 2;
        wb_data = 16'h2222;
        #1;
        chk("raw_release", 32'(if_ready), 1);
        tick;
        wb_en = 0;
        if_valid = 0;
        chk("raw_valid", 32'(id_valid), 1);
        chk("raw_op1", 32'(op_1_reg_value), 32'h2222);
`else
        #1;
        chk("nostall_ready", 32'(if_ready), 1);
        tick;
        if_valid = 0;
        chk("nostall_valid", 32'(id_valid), 1);
        chk("nostall_ptr", 32'(pointer_reg), 2);
        chk("nostall_op1", 32'(op_1_reg_value), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
